// File: rtl/memory_load_arbiter_if.sv
// Bundles the instruction/data load channels and the shared memory load port.
// The slave modport is the arbiter's view; the master modport is its environment.
interface memory_load_arbiter_if;
   logic        icache_request_i;
   logic [31:0] icache_address_i;
   logic        icache_lock_i;
   logic        icache_grant_o;
   logic [31:0] icache_data_o;
   logic        icache_valid_o;

   logic        dcache_request_i;
   logic [31:0] dcache_address_i;
   logic        dcache_lock_i;
   logic        dcache_grant_o;
   logic [31:0] dcache_data_o;
   logic        dcache_valid_o;

   logic        mem_request_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_i;
   logic        mem_valid_i;

   logic        timeout_o;

   modport slave (
      input  icache_request_i, icache_address_i, icache_lock_i,
      output icache_grant_o, icache_data_o, icache_valid_o,
      input  dcache_request_i, dcache_address_i, dcache_lock_i,
      output dcache_grant_o, dcache_data_o, dcache_valid_o,
      output mem_request_o, mem_address_o,
      input  mem_data_i, mem_valid_i,
      output timeout_o
   );

   modport master (
      output icache_request_i, icache_address_i, icache_lock_i,
      input  icache_grant_o, icache_data_o, icache_valid_o,
      output dcache_request_i, dcache_address_i, dcache_lock_i,
      input  dcache_grant_o, dcache_data_o, dcache_valid_o,
      input  mem_request_o, mem_address_o,
      output mem_data_i, mem_valid_i,
      input  timeout_o
   );
endinterface

// File: rtl/memory_load_arbiter.sv
// Round-robin arbiter sharing one memory load port between icache refill and dcache loads,
// with line-refill locking and a watchdog that aborts a transaction memory never answers.
module memory_load_arbiter #(
   parameter int TIMEOUT = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   memory_load_arbiter_if.slave bus
);
   localparam int   CW     = $clog2(TIMEOUT) + 1;
   localparam logic SIDE_D = 1'b1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t        state_reg;
   logic          owner_reg;
   logic          ptr_reg;
   logic          locked_reg;
   logic          timeout_reg;
   logic          mem_request_reg;
   logic [31:0]   mem_address_reg;
   logic [CW-1:0] count_reg;

   // Index 0 is the instruction side, index 1 the data side.
   logic [1:0]  request;
   logic [1:0]  lock;
   logic [1:0]  grant;
   logic [1:0]  valid;
   logic [31:0] address [2];
   logic [31:0] data [2];
   logic        keep_lock;
   logic        pick;
   logic        mem_done;
   logic        timeout_hit;

   assign request    = {bus.dcache_request_i, bus.icache_request_i};
   assign lock       = {bus.dcache_lock_i, bus.icache_lock_i};
   assign address[0] = bus.icache_address_i;
   assign address[1] = bus.dcache_address_i;

   // A held lock only survives while the owner keeps both request and lock up;
   // otherwise normal arbitration applies in the very same IDLE cycle.
   always_comb begin
      keep_lock = locked_reg & request[owner_reg] & lock[owner_reg];
      pick      = request[SIDE_D];
      if (keep_lock) begin
         pick = owner_reg;
      end else if (&request) begin
         pick = ptr_reg;
      end
   end

   assign mem_done    = (state_reg == ST_WAIT) & bus.mem_valid_i;
   assign timeout_hit = (state_reg == ST_WAIT) & ~bus.mem_valid_i & (count_reg == CW'(TIMEOUT));

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_side
      assign grant[gi] = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
      assign valid[gi] = (mem_done || timeout_hit) && (owner_reg == 1'(gi));
      assign data[gi]  = (mem_done && (owner_reg == 1'(gi))) ? bus.mem_data_i : 32'd0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg       <= ST_IDLE;
         owner_reg       <= 1'b0;
         ptr_reg         <= SIDE_D;
         locked_reg      <= 1'b0;
         timeout_reg     <= 1'b0;
         mem_request_reg <= 1'b0;
         mem_address_reg <= 32'd0;
         count_reg       <= '0;
      end else begin
         mem_request_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               locked_reg <= keep_lock;
               if (|request) begin
                  owner_reg       <= pick;
                  mem_address_reg <= address[pick];
                  mem_request_reg <= 1'b1;
                  state_reg       <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               count_reg <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.mem_valid_i) begin
                  locked_reg <= lock[owner_reg];
                  if (!lock[owner_reg]) begin
                     ptr_reg <= ~owner_reg;
                  end
                  state_reg <= ST_IDLE;
               end else if (count_reg == CW'(TIMEOUT)) begin
                  locked_reg  <= 1'b0;
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_IDLE;
               end else begin
                  count_reg <= count_reg + CW'(1);
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.icache_grant_o = grant[0];
   assign bus.icache_valid_o = valid[0];
   assign bus.icache_data_o  = data[0];
   assign bus.dcache_grant_o = grant[1];
   assign bus.dcache_valid_o = valid[1];
   assign bus.dcache_data_o  = data[1];
   assign bus.mem_request_o  = mem_request_reg;
   assign bus.mem_address_o  = mem_address_reg;
   assign bus.timeout_o      = timeout_reg;
endmodule

// File: doc/memory_load_arbiter.md
# memory_load_arbiter

Shares the single external memory load port between the instruction-fetch refill path and the data-cache load controller. It accepts one-word load requests from two requesters and grants the port round-robin. A lock input holds the grant across a multi-word cache-line refill. Each transaction is sequenced through a three-state FSM, with a watchdog timeout. The block sits between the two cache complexes and the bus-side load channel.

## Interface
- TIMEOUT, 256: cycles spent in WAIT without `mem_valid_i` before the transaction is aborted.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- icache_request_i  in  1  instruction-side load request; held until `icache_valid_o`.
- icache_address_i  in  32  word address; stable while the request is high.
- icache_lock_i  in  1  keep the grant after this word completes (line refill).
- icache_grant_o  out  1  instruction side owns the port.
- icache_data_o  out  32  returned word.
- icache_valid_o  out  1  one-cycle completion pulse.
- dcache_request_i, dcache_address_i, dcache_lock_i, dcache_grant_o, dcache_data_o, dcache_valid_o: same as the icache_* ports, for the data side.
- mem_request_o  out  1  one-cycle request pulse to memory.
- mem_address_o  out  32  registered address of the granted request.
- mem_data_i  in  32  memory read data.
- mem_valid_i  in  1  read data valid.
- timeout_o  out  1  sticky abort flag.

## Operation
- FSM states:
  - IDLE: pick an eligible requester, latch its owner ID and address, go to ISSUE.
  - ISSUE: `mem_request_o` = 1 for this one cycle, then go to WAIT.
  - WAIT: on `mem_valid_i`, complete the transaction and go to IDLE.
- Eligibility:
  - If the locked flag is set, only the owner is eligible.
  - Otherwise, if both requesters ask, the one selected by the round-robin pointer wins; a single requester always wins.
- Round-robin pointer:
  - Reset value selects dcache.
  - After an unlocked completion, the pointer moves to the non-owner.
  - Locked completions do not move the pointer.
- Lock:
  - Sampled in the owner's completion cycle; `lock_i` = 1 sets the locked flag.
  - In IDLE, the flag clears if the owner's `lock_i` is 0 or its request is 0. The other requester is then eligible in that same cycle.
- Completion:
  - `<owner>_data_o` = `mem_data_i` and `<owner>_valid_o` = 1, combinationally in the `mem_valid_i` cycle.
  - The non-owner's data output is 0.
- `mem_valid_i` in IDLE or ISSUE is ignored; memory guarantees at least 1 cycle of latency after the request.
- Timeout:
  - A 9-bit counter (width `$clog2(TIMEOUT)+1`) clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without `mem_valid_i`, the owner gets `valid_o` = 1 with data 0, `timeout_o` sets (sticky until `rst_i`), the locked flag clears, and the FSM goes to IDLE.
- `<owner>_grant_o` is high in ISSUE and WAIT, including the completion cycle.

## Timing
- Reset values:
  - State IDLE, pointer = dcache, locked flag = 0, counter = 0.
  - `mem_request_o` = 0, `mem_address_o` = 0, all `grant_o`/`valid_o`/data outputs = 0, `timeout_o` = 0.
- Cycle sequence: request seen in IDLE at cycle N → `mem_request_o`/`mem_address_o` at N+1 → earliest completion at N+2.
- Minimum issue interval is 3 cycles per word; a locked back-to-back request re-issues at completion+2.
- Requests must stay stable from assertion until `valid_o`; deasserting a request after grant does not cancel the memory transaction, and its data is discarded.
- A request asserted in the completion cycle is seen in the following IDLE cycle.
- `rst_i` mid-transaction forces IDLE next cycle; a later `mem_valid_i` for the dropped transaction is ignored.

## Test plan
- Single dcache request, address 0x0000_1000, memory replies 2 cycles after `mem_request_o` with 0xDEADBEEF:
  - `mem_request_o` pulses at cycle 1 with address 0x1000.
  - `dcache_valid_o`/`dcache_data_o` = 0xDEADBEEF at cycle 3.
  - `icache_valid_o` stays 0.
- Both request simultaneously after reset, without lock:
  - Order is dcache, icache, dcache, icache across 4 held requests.
  - Each `valid_o` pulses exactly once per grant.
- icache locked refill of 4 words (`lock_i` = 1 on words 1–3, 0 on word 4) while dcache requests continuously:
  - All 4 icache words complete before the first dcache grant.
  - The pointer then selects dcache.
- Memory never answers, TIMEOUT = 256:
  - Exactly 256 WAIT cycles, then the owner sees `valid_o` = 1 with data 0.
  - `timeout_o` = 1 and stays set.
  - The next request still issues normally.
- `rst_i` asserted during WAIT, followed by a stale `mem_valid_i`:
  - All outputs return to their reset values.
  - No `valid_o` pulse occurs.
  - The pointer returns to dcache.
